seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 137 +++++++++++++
 tb/tb_seq_divider.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle over WIDTH RUN
// cycles, with registered results and a one-cycle done pulse. A zero divisor
// skips the iteration and reports all-ones quotient, dividend as remainder.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   r_q, r_d;        // partial remainder, one guard bit
   logic [WIDTH-1:0] q_q, q_d;        // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] d_q, d_d;        // captured divisor
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   r_sub;
   logic [WIDTH-1:0] q_shift;

   // State and datapath registers; reset aborts any operation silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         r_q         <= r_d;
         q_q         <= q_d;
         d_q         <= d_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state, restoring step and result publication.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      r_d         = r_q;
      q_d         = q_q;
      d_d         = d_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      done_d      = 1'b0;

      // Shift the next dividend bit into the partial remainder, then trial-subtract.
      r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
      q_shift = {q_q[WIDTH-2:0], 1'b0};
      r_sub   = r_shift - {1'b0, d_q};

      case (state_q)
         IDLE: begin
            if (start) begin
               d_d     = divisor;
               q_d     = dividend;
               r_d     = '0;
               cnt_d   = CW'(WIDTH);
               dbz_d   = 1'b0;
               state_d = (divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (r_shift >= {1'b0, d_q}) begin
               r_d = r_sub;
               q_d = q_shift | WIDTH'(1);
            end else begin
               r_d = r_shift;
               q_d = q_shift;
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_d = 1'b1;
            if (d_q == '0) begin
               // q_q still holds the untouched dividend on this path.
               quotient_d  = '1;
               remainder_d = q_q;
               dbz_d       = 1'b1;
            end else begin
               quotient_d  = q_q;
               remainder_d = r_q[WIDTH-1:0];
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases plus randomized operands on 8-bit and
// 16-bit instances, checked against plain arithmetic division.
module tb_seq_divider;

   logic        clk;
   logic        rst;

   logic        start8, busy8, done8, dbz8;
   logic [7:0]  dvd8, dvs8, quo8, rem8;
   logic        start16, busy16, done16, dbz16;
   logic [15:0] dvd16, dvs16, quo16, rem16;

   int n_pass;
   int n_total;

   logic [31:0] last_q [2];
   logic [31:0] last_r [2];

   seq_divider #(.WIDTH(8)) dut8 (
      .clk         (clk),
      .rst         (rst),
      .start       (start8),
      .dividend    (dvd8),
      .divisor     (dvs8),
      .busy        (busy8),
      .done        (done8),
      .quotient    (quo8),
      .remainder   (rem8),
      .div_by_zero (dbz8)
   );

   seq_divider #(.WIDTH(16)) dut16 (
      .clk         (clk),
      .rst         (rst),
      .start       (start16),
      .dividend    (dvd16),
      .divisor     (dvs16),
      .busy        (busy16),
      .done        (done16),
      .quotient    (quo16),
      .remainder   (rem16),
      .div_by_zero (dbz16)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] get_done(input int w);
      return (w == 16) ? {31'd0, done16} : {31'd0, done8};
   endfunction

   function automatic logic [31:0] get_busy(input int w);
      return (w == 16) ? {31'd0, busy16} : {31'd0, busy8};
   endfunction

   function automatic logic [31:0] get_dbz(input int w);
      return (w == 16) ? {31'd0, dbz16} : {31'd0, dbz8};
   endfunction

   function automatic logic [31:0] get_q(input int w);
      return (w == 16) ? {16'd0, quo16} : {24'd0, quo8};
   endfunction

   function automatic logic [31:0] get_r(input int w);
      return (w == 16) ? {16'd0, rem16} : {24'd0, rem8};
   endfunction

   task automatic drive(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
      if (w == 16) begin
         start16 = s;
         dvd16   = a[15:0];
         dvs16   = b[15:0];
      end else begin
         start8 = s;
         dvd8   = a[7:0];
         dvs8   = b[7:0];
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // One division from an IDLE cycle (called at a negedge). Returns at the
   // negedge of the done cycle, so another call right after is back-to-back.
   task automatic op(input int w, input logic [31:0] a, input logic [31:0] b,
                     input bit hold, input string tag);
      logic [31:0] mask, ea, eb, eq, er;
      int          lat, exp_lat, idx;
      idx     = (w == 16) ? 1 : 0;
      mask    = (w == 16) ? 32'h0000_FFFF : 32'h0000_00FF;
      ea      = a & mask;
      eb      = b & mask;
      eq      = (eb == 0) ? mask : ea / eb;
      er      = (eb == 0) ? ea : ea % eb;
      exp_lat = (eb == 0) ? 1 : w + 1;
      drive(w, 1'b1, ea, eb);
      @(negedge clk);
      check($sformatf("%s/acc_busy", tag), get_busy(w), 32'd1);
      check($sformatf("%s/acc_done", tag), get_done(w), 32'd0);
      check($sformatf("%s/acc_dbz", tag), get_dbz(w), 32'd0);
      check($sformatf("%s/hold_q", tag), get_q(w), last_q[idx]);
      // Disturb the operand inputs after capture.
      drive(w, hold, $urandom & mask, $urandom & mask);
      lat = 0;
      while (get_done(w) !== 32'd1 && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("%s/latency", tag), lat, exp_lat);
      check($sformatf("%s/quotient", tag), get_q(w), eq);
      check($sformatf("%s/remainder", tag), get_r(w), er);
      check($sformatf("%s/dbz", tag), get_dbz(w), (eb == 0) ? 32'd1 : 32'd0);
      check($sformatf("%s/done_busy", tag), get_busy(w), 32'd0);
      last_q[idx] = eq;
      last_r[idx] = er;
   endtask

   initial begin
      int          pulses;
      int          first_lat;
      int          busy_seen;
      logic [31:0] a, b, got_q, got_r;
      int          w;
      n_pass    = 0;
      n_total   = 0;
      last_q[0] = 0;
      last_q[1] = 0;
      last_r[0] = 0;
      last_r[1] = 0;

      // Reset
      rst = 1'b1;
      drive(8, 1'b0, 0, 0);
      drive(16, 1'b0, 0, 0);
      repeat (3) @(negedge clk);
      check("rst/busy", get_busy(8), 32'd0);
      check("rst/done", get_done(8), 32'd0);
      check("rst/q", get_q(8), 32'd0);
      check("rst/r", get_r(8), 32'd0);
      check("rst/dbz", get_dbz(8), 32'd0);
      check("rst/busy16", get_busy(16), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases
      op(8, 100, 7, 1'b0, "d100_7");
      op(8, 5, 9, 1'b0, "d5_9");
      op(8, 255, 1, 1'b0, "d255_1");
      op(8, 0, 3, 1'b0, "d0_3");
      op(8, 37, 0, 1'b0, "d37_0");
      op(8, 10, 3, 1'b0, "d10_3");
      drive(8, 1'b0, 0, 0);
      @(negedge clk);
      check("pulse_width", get_done(8), 32'd0);

      // Start pulsed mid-RUN with other operands must be ignored.
      drive(8, 1'b1, 100, 7);
      @(negedge clk);
      pulses    = 0;
      first_lat = -1;
      got_q     = 0;
      got_r     = 0;
      for (int i = 0; i < 20; i++) begin
         if (done8 === 1'b1) begin
            pulses++;
            if (pulses == 1) begin
               first_lat = i;
               got_q     = get_q(8);
               got_r     = get_r(8);
            end
         end
         if (i == 2) drive(8, 1'b1, 200, 9);
         else drive(8, 1'b0, $urandom, $urandom);
         @(negedge clk);
      end
      check("glitch/pulses", pulses, 32'd1);
      check("glitch/latency", first_lat, 32'd9);
      check("glitch/q", got_q, 32'd14);
      check("glitch/r", got_r, 32'd2);
      last_q[0] = 14;
      last_r[0] = 2;

      // Reset in the fourth RUN cycle aborts without a done pulse.
      drive(8, 1'b1, 100, 7);
      @(negedge clk);
      drive(8, 1'b0, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort/busy", get_busy(8), 32'd0);
      check("abort/done", get_done(8), 32'd0);
      check("abort/q", get_q(8), 32'd0);
      check("abort/r", get_r(8), 32'd0);
      check("abort/dbz", get_dbz(8), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses    = 0;
      busy_seen = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (done8 === 1'b1) pulses++;
         if (busy8 === 1'b1) busy_seen++;
      end
      check("abort/no_done", pulses, 32'd0);
      check("abort/no_busy", busy_seen, 32'd0);
      last_q[0] = 0;
      last_r[0] = 0;
      last_q[1] = 0;
      last_r[1] = 0;
      op(8, 60, 6, 1'b0, "d60_6");
      drive(8, 1'b0, 0, 0);
      @(negedge clk);

      // Randomized operands, separate and back-to-back with start held high.
      for (int wi = 0; wi < 2; wi++) begin
         w = (wi == 1) ? 16 : 8;
         for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < 20; k++) begin
               a = $urandom;
               case ($urandom_range(0, 3))
                  0:       b = 0;
                  1:       b = $urandom_range(1, 15);
                  default: b = $urandom;
               endcase
               if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 3);
               op(w, a, b, bit'(h), $sformatf("rnd%0d_h%0d_%0d", w, h, k));
               if (h == 0) begin
                  drive(w, 1'b0, 0, 0);
                  @(negedge clk);
               end
            end
            drive(w, 1'b0, 0, 0);
            @(negedge clk);
            check($sformatf("rnd%0d_h%0d/end_done", w, h), get_done(w), 32'd0);
            check($sformatf("rnd%0d_h%0d/end_busy", w, h), get_busy(w), 32'd0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
